// File: rtl/demokit_pkg.sv
// Shared constants and types for the demo kit gamepad input path.
// Pad field layout: bit 11 is B down to bit 0 is R.
package demokit_pkg;

   localparam int FRAME_BITS = 24;
   localparam int PAD_BITS   = 12;

   localparam int BTN_B      = 11;
   localparam int BTN_Y      = 10;
   localparam int BTN_SELECT = 9;
   localparam int BTN_START  = 8;
   localparam int BTN_UP     = 7;
   localparam int BTN_DOWN   = 6;
   localparam int BTN_LEFT   = 5;
   localparam int BTN_RIGHT  = 4;
   localparam int BTN_A      = 3;
   localparam int BTN_X      = 2;
   localparam int BTN_L      = 1;
   localparam int BTN_R      = 0;

   typedef enum logic {SYNCING, SHIFT} gp_state_t;

   // The PMOD reports a disconnected pad as an all-ones field.
   function automatic logic pad_absent(input logic [PAD_BITS-1:0] field);
      return &field;
   endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchronizer for one asynchronous input, plus a rising-edge strobe
// derived combinationally from the synchronized level and its previous value.
module sync_edge #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout,
   output logic rise
);

   logic [SYNC_STAGES-1:0] chain;
   logic                   prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chain <= '0;
         prev  <= 1'b0;
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], din};
         prev  <= chain[SYNC_STAGES-1];
      end
   end

   assign dout = chain[SYNC_STAGES-1];
   assign rise = dout & ~prev;

endmodule

// File: rtl/gamepad_pmod_rx.sv
// Gamepad PMOD receiver: shifts the serial stream on PMOD clock edges and commits
// both pad button vectors on a latch edge when exactly one full frame was received.
module gamepad_pmod_rx
   import demokit_pkg::*;
#(
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                pmod_data,
   input  logic                pmod_clk,
   input  logic                pmod_latch,
   output logic [PAD_BITS-1:0] pad0_btn,
   output logic [PAD_BITS-1:0] pad1_btn,
   output logic                pad0_present,
   output logic                pad1_present,
   output logic                frame_valid,
   output logic                frame_err,
   output logic                stale
);

   localparam int unsigned     WD_W     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_MAX   = WD_W'(TIMEOUT_CYCLES);
   localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [4:0]      FULL_CNT = 5'(FRAME_BITS);

   logic data_sync, data_rise;
   logic clk_sync, clk_rise;
   logic latch_sync, latch_rise;
   logic unused_sync;

   gp_state_t             state;
   logic [FRAME_BITS-1:0] shreg;
   logic [4:0]            bitcnt;
   logic [WD_W-1:0]       wd_cnt;
   logic [PAD_BITS-1:0]   field0, field1;

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
      .clk  (clk),
      .rst  (rst),
      .din  (pmod_data),
      .dout (data_sync),
      .rise (data_rise)
   );

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
      .clk  (clk),
      .rst  (rst),
      .din  (pmod_clk),
      .dout (clk_sync),
      .rise (clk_rise)
   );

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_latch (
      .clk  (clk),
      .rst  (rst),
      .din  (pmod_latch),
      .dout (latch_sync),
      .rise (latch_rise)
   );

   assign unused_sync = ^{data_rise, clk_sync, latch_sync};

   // First bit received lands in the MSB, so pad 0 occupies the upper half.
   assign field0 = shreg[FRAME_BITS-1:PAD_BITS];
   assign field1 = shreg[PAD_BITS-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= SYNCING;
         shreg        <= '0;
         bitcnt       <= '0;
         wd_cnt       <= '0;
         pad0_btn     <= '0;
         pad1_btn     <= '0;
         pad0_present <= 1'b0;
         pad1_present <= 1'b0;
         frame_valid  <= 1'b0;
         frame_err    <= 1'b0;
         stale        <= 1'b1;
      end else begin
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;

         if (wd_cnt != WD_MAX) begin
            wd_cnt <= wd_cnt + 1'b1;
         end
         if (wd_cnt == WD_LAST) begin
            stale        <= 1'b1;
            pad0_present <= 1'b0;
            pad1_present <= 1'b0;
            pad0_btn     <= '0;
            pad1_btn     <= '0;
         end

         // A latch edge takes priority; a coincident shift-clock edge is dropped.
         case (state)
            SYNCING: begin
               if (latch_rise) begin
                  bitcnt <= '0;
                  state  <= SHIFT;
               end
            end
            SHIFT: begin
               if (latch_rise) begin
                  bitcnt <= '0;
                  if (bitcnt == FULL_CNT) begin
                     wd_cnt       <= '0;
                     stale        <= 1'b0;
                     frame_valid  <= 1'b1;
                     pad0_present <= ~pad_absent(field0);
                     pad1_present <= ~pad_absent(field1);
                     pad0_btn     <= pad_absent(field0) ? '0 : field0;
                     pad1_btn     <= pad_absent(field1) ? '0 : field1;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end else if (clk_rise) begin
                  shreg <= {shreg[FRAME_BITS-2:0], data_sync};
                  if (bitcnt != 5'd31) begin
                     bitcnt <= bitcnt + 1'b1;
                  end
               end
            end
            default: state <= SYNCING;
         endcase
      end
   end

endmodule

// File: tb/tb_gamepad_pmod_rx.sv
// Self-checking bench for gamepad_pmod_rx: directed frame table, randomized frames
// against a frame-level model, and hand-written sequences for the multi-cycle corners.
module tb_gamepad_pmod_rx;
   import demokit_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic pmod_data = 1'b0, pmod_clk = 1'b0, pmod_latch = 1'b0;

   logic [11:0] pad0_btn, pad1_btn, to_pad0_btn, to_pad1_btn;
   logic pad0_present, pad1_present, frame_valid, frame_err, stale;
   logic to_pad0_present, to_pad1_present, to_frame_valid, to_frame_err, to_stale;

   always #5 clk = ~clk;

   gamepad_pmod_rx #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(5000)) dut (
      .clk          (clk),
      .rst          (rst),
      .pmod_data    (pmod_data),
      .pmod_clk     (pmod_clk),
      .pmod_latch   (pmod_latch),
      .pad0_btn     (pad0_btn),
      .pad1_btn     (pad1_btn),
      .pad0_present (pad0_present),
      .pad1_present (pad1_present),
      .frame_valid  (frame_valid),
      .frame_err    (frame_err),
      .stale        (stale)
   );

   gamepad_pmod_rx #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(100)) dut_to (
      .clk          (clk),
      .rst          (rst),
      .pmod_data    (pmod_data),
      .pmod_clk     (pmod_clk),
      .pmod_latch   (pmod_latch),
      .pad0_btn     (to_pad0_btn),
      .pad1_btn     (to_pad1_btn),
      .pad0_present (to_pad0_present),
      .pad1_present (to_pad1_present),
      .frame_valid  (to_frame_valid),
      .frame_err    (to_frame_err),
      .stale        (to_stale)
   );

   int total = 0;
   int bad   = 0;
   int n_valid = 0;
   int n_err   = 0;

   always @(posedge clk) begin
      if (frame_valid) n_valid <= n_valid + 1;
      if (frame_err)   n_err   <= n_err + 1;
   end

   // Frame-level reference model of the main instance.
   logic [11:0] m_btn0, m_btn1;
   logic        m_pr0, m_pr1, m_stale, m_synced;

   task automatic model_reset();
      m_btn0 = '0; m_btn1 = '0; m_pr0 = 0; m_pr1 = 0; m_stale = 1; m_synced = 0;
   endtask

   task automatic model_latch(input logic [23:0] f, input int n, output int ev, output int ee);
      if (!m_synced) begin
         m_synced = 1; ev = 0; ee = 0;
      end else if (n == 24) begin
         ev = 1; ee = 0; m_stale = 0;
         m_pr0  = (f[23:12] != 12'hFFF);
         m_pr1  = (f[11:0] != 12'hFFF);
         m_btn0 = m_pr0 ? f[23:12] : 12'h000;
         m_btn1 = m_pr1 ? f[11:0] : 12'h000;
      end else begin
         ev = 0; ee = 1;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", name, act, exp);
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".pad0_btn"}, 32'(pad0_btn), 32'(m_btn0));
      chk({tag, ".pad1_btn"}, 32'(pad1_btn), 32'(m_btn1));
      chk({tag, ".pad0_present"}, 32'(pad0_present), 32'(m_pr0));
      chk({tag, ".pad1_present"}, 32'(pad1_present), 32'(m_pr1));
      chk({tag, ".stale"}, 32'(stale), 32'(m_stale));
   endtask

   task automatic send_bit(input logic b);
      pmod_data = b;
      repeat (2) @(negedge clk);
      pmod_clk = 1'b1;
      repeat (2) @(negedge clk);
      pmod_clk = 1'b0;
   endtask

   task automatic send_bits(input logic [23:0] f, input int n);
      logic b;
      for (int i = 0; i < n; i++) begin
         b = 1'b0;
         if (i < 24) b = f[23-i];
         send_bit(b);
      end
   endtask

   task automatic do_latch(output int dv, output int de);
      int v0, e0;
      v0 = n_valid; e0 = n_err;
      @(negedge clk);
      pmod_latch = 1'b1;
      repeat (3) @(negedge clk);
      pmod_latch = 1'b0;
      repeat (4) @(negedge clk);
      dv = n_valid - v0;
      de = n_err - e0;
   endtask

   task automatic frame(input logic [23:0] f, input int n, output int dv, output int de);
      send_bits(f, n);
      do_latch(dv, de);
   endtask

   typedef struct {
      logic [11:0] p0, p1;
      int          nbits;
      logic [11:0] e_b0, e_b1;
      logic        e_pr0, e_pr1;
      int          e_v, e_e;
   } vec_t;

   vec_t vecs[6];

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got=running want=finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      int dv, de, mv, me, seen;
      logic [23:0] f;
      logic [11:0] r0, r1;
      int n;

      vecs[0] = '{12'((1 << BTN_B) | (1 << BTN_R)), 12'h0F0, 24, 12'h801, 12'h0F0, 1, 1, 1, 0};
      vecs[1] = '{12'h010, 12'hFFF, 24, 12'h010, 12'h000, 1, 0, 1, 0};
      vecs[2] = '{12'h123, 12'h456, 23, 12'h010, 12'h000, 1, 0, 0, 1};
      vecs[3] = '{12'h321, 12'h654, 24, 12'h321, 12'h654, 1, 1, 1, 0};
      vecs[4] = '{12'hFFF, 12'h000, 24, 12'h000, 12'h000, 0, 1, 1, 0};
      vecs[5] = '{12'h555, 12'hAAA, 25, 12'h000, 12'h000, 0, 1, 0, 1};

      model_reset();
      repeat (3) @(negedge clk);
      chk_model("reset");
      chk("reset.frame_valid", 32'(frame_valid), 0);
      chk("reset.frame_err", 32'(frame_err), 0);
      rst = 1'b0;

      // Sync frame: only leaves SYNCING.
      frame(24'h801_0F0, 24, dv, de);
      model_latch(24'h801_0F0, 24, mv, me);
      chk("sync.valid", 32'(dv), 0);
      chk("sync.err", 32'(de), 0);
      chk_model("sync");

      for (int i = 0; i < 6; i++) begin
         frame({vecs[i].p0, vecs[i].p1}, vecs[i].nbits, dv, de);
         model_latch({vecs[i].p0, vecs[i].p1}, vecs[i].nbits, mv, me);
         chk($sformatf("vec%0d.valid", i), 32'(dv), 32'(vecs[i].e_v));
         chk($sformatf("vec%0d.err", i), 32'(de), 32'(vecs[i].e_e));
         chk($sformatf("vec%0d.pad0_btn", i), 32'(pad0_btn), 32'(vecs[i].e_b0));
         chk($sformatf("vec%0d.pad1_btn", i), 32'(pad1_btn), 32'(vecs[i].e_b1));
         chk($sformatf("vec%0d.pad0_present", i), 32'(pad0_present), 32'(vecs[i].e_pr0));
         chk($sformatf("vec%0d.pad1_present", i), 32'(pad1_present), 32'(vecs[i].e_pr1));
         chk($sformatf("vec%0d.stale", i), 32'(stale), 0);
      end

      for (int r = 0; r < 20; r++) begin
         r0 = 12'($urandom_range(0, 4095));
         r1 = 12'($urandom_range(0, 4095));
         if ($urandom_range(0, 3) == 0) r0 = 12'hFFF;
         if ($urandom_range(0, 3) == 0) r1 = 12'hFFF;
         case ($urandom_range(0, 5))
            0:       n = 23;
            1:       n = 25;
            default: n = 24;
         endcase
         frame({r0, r1}, n, dv, de);
         model_latch({r0, r1}, n, mv, me);
         chk($sformatf("rnd%0d.valid", r), 32'(dv), 32'(mv));
         chk($sformatf("rnd%0d.err", r), 32'(de), 32'(me));
         chk_model($sformatf("rnd%0d", r));
      end

      // Shift clock and latch rise together after a full frame.
      f = 24'hA5C_396;
      send_bits(f, 24);
      begin
         int v0, e0;
         v0 = n_valid; e0 = n_err;
         @(negedge clk);
         pmod_data = 1'b1;
         repeat (2) @(negedge clk);
         pmod_clk = 1'b1;
         pmod_latch = 1'b1;
         repeat (3) @(negedge clk);
         pmod_clk = 1'b0;
         pmod_latch = 1'b0;
         repeat (4) @(negedge clk);
         dv = n_valid - v0;
         de = n_err - e0;
      end
      model_latch(f, 24, mv, me);
      chk("simul.valid", 32'(dv), 1);
      chk("simul.err", 32'(de), 0);
      chk_model("simul");
      frame(24'h3C5_A0F, 24, dv, de);
      model_latch(24'h3C5_A0F, 24, mv, me);
      chk("after_simul.valid", 32'(dv), 1);
      chk("after_simul.err", 32'(de), 0);
      chk_model("after_simul");

      // Watchdog boundary on the short-timeout instance.
      f = 24'h042_008;
      send_bits(f, 24);
      @(negedge clk);
      pmod_latch = 1'b1;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (to_frame_valid) begin
            seen = 1;
            break;
         end
      end
      model_latch(f, 24, mv, me);
      chk("to.commit_seen", 32'(seen), 1);
      repeat (3) @(negedge clk);
      pmod_latch = 1'b0;
      repeat (96) @(negedge clk);
      chk("to.stale_at_99", 32'(to_stale), 0);
      chk("to.pad0_at_99", 32'(to_pad0_btn), 32'h042);
      chk("to.pr0_at_99", 32'(to_pad0_present), 1);
      @(negedge clk);
      chk("to.stale_at_100", 32'(to_stale), 1);
      chk("to.pad0_at_100", 32'(to_pad0_btn), 0);
      chk("to.pad1_at_100", 32'(to_pad1_btn), 0);
      chk("to.pr0_at_100", 32'(to_pad0_present), 0);
      chk("to.pr1_at_100", 32'(to_pad1_present), 0);
      chk_model("main_during_to");
      frame(24'h00F_FFF, 24, dv, de);
      model_latch(24'h00F_FFF, 24, mv, me);
      chk("to.stale_cleared", 32'(to_stale), 0);
      chk("to.pad0_after", 32'(to_pad0_btn), 32'h00F);
      chk("to.pr1_after", 32'(to_pad1_present), 0);
      chk_model("to_recover");

      // Reset after 12 bits of a frame.
      f = 24'h9AB_CDE;
      send_bits(f, 12);
      rst = 1'b1;
      #1;
      model_reset();
      chk_model("midrst");
      chk("midrst.to_stale", 32'(to_stale), 1);
      chk("midrst.to_pad0", 32'(to_pad0_btn), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      send_bits(24'hBCD_E00, 12);
      do_latch(dv, de);
      model_latch(f, 12, mv, me);
      chk("midrst.valid", 32'(dv), 0);
      chk("midrst.err", 32'(de), 0);
      chk_model("midrst_latch");
      frame(24'h246_135, 24, dv, de);
      model_latch(24'h246_135, 24, mv, me);
      chk("midrst_next.valid", 32'(dv), 1);
      chk("midrst_next.err", 32'(de), 0);
      chk_model("midrst_next");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
